// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits,
// with a one-word holding register so back-to-back frames leave no idle gap.
module uart_tx #(
    parameter int CLK_FREQ   = 14745600,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] send_data,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  line
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shnext;
    logic [DATA_WIDTH-1:0] hold;
    logic                  pending;
    logic                  accept;
    logic                  bit_done;
    logic                  last_stop;
    logic                  park;

    // Assert asynchronously, release two edges later so the FSM never sees a partial release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign ready     = !pending;
    assign accept    = start && !pending;
    assign bit_done  = (cnt == CNT_LAST);
    assign last_stop = (state == STOP) && bit_done && (stop_idx == STOP_LAST);
    assign shnext    = shreg >> 1;
    // Words arriving mid-frame go to the holding slot, except on the final stop edge
    // where an empty slot lets the word launch directly.
    assign park      = accept && (state != IDLE) && !last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            line     <= 1'b1;
            busy     <= 1'b0;
            pending  <= 1'b0;
            hold     <= '0;
            shreg    <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            cnt <= bit_done ? '0 : cnt + 1'b1;
            if (park) begin
                hold    <= send_data;
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        shreg <= send_data;
                        state <= START;
                        line  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        line    <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_LAST) begin
                            state    <= STOP;
                            line     <= 1'b1;
                            stop_idx <= 1'b0;
                        end else begin
                            shreg   <= shnext;
                            line    <= shnext[0];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        if (pending) begin
                            shreg   <= hold;
                            pending <= 1'b0;
                            state   <= START;
                            line    <= 1'b0;
                        end else if (accept) begin
                            shreg <= send_data;
                            state <= START;
                            line  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (bit_done) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    line  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frame checks, hand-written corner sequences, random
// traffic against a timing model, and independent mid-bit receivers on both lines.
module tb_uart_tx;

    localparam int CPB  = 128;
    localparam int F1   = 1280;
    localparam int CPB2 = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic [7:0] send_data = 8'h00, send_data2 = 8'h00;
    logic       ready, busy, line, ready2, busy2, line2;

    always #5 clk = ~clk;

    uart_tx u_dut (
        .clk(clk), .reset(reset), .send_data(send_data), .start(start),
        .ready(ready), .busy(busy), .line(line)
    );

    uart_tx #(.CLK_FREQ(1600), .BAUDRATE(100), .DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .send_data(send_data2), .start(start2),
        .ready(ready2), .busy(busy2), .line(line2)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;   // expected line bits, MSB = first data bit on the wire
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    longint     cyc = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    bit         m_pend = 1'b0;
    longint     m_end = -1000000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a frame launched at edge t owns the line until edge t+F1; one word may wait.
    task automatic attempt(input logic [7:0] d, output bit acc);
        longint t;
        t = cyc + 1;
        while (m_pend && m_end < t) begin
            m_end  = m_end + F1;
            m_pend = 1'b0;
        end
        acc = !m_pend;
        chk("ready_vs_model", longint'(ready === 1'b1), longint'(acc));
        start     = 1'b1;
        send_data = d;
        @(posedge clk);
        if (acc) begin
            q1.push_back(d);
            if (t >= m_end) m_end = t + F1;
            else            m_pend = 1'b1;
        end
        @(negedge clk);
        start     = 1'b0;
        send_data = 8'($urandom);
    endtask

    task automatic model_reset();
        m_pend = 1'b0;
        m_end  = -1000000;
        q1.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || busy2 !== 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", longint'(n < 5000), 1);
    endtask

    task automatic run_vec(input int tag, input logic [7:0] d, input logic [7:0] seq);
        bit   acc;
        int   err[10];
        int   nb;
        int   c;
        logic e;
        nb = 0;
        foreach (err[j]) err[j] = 0;
        attempt(d, acc);
        for (int k = 0; k < F1 + 10; k++) begin
            c = k / CPB;
            if (c > 9) c = 9;
            if (c == 0)      e = 1'b0;
            else if (c == 9) e = 1'b1;
            else             e = seq[8 - c];
            if (line !== e) err[c]++;
            if (busy === 1'b1) nb++;
            @(negedge clk);
        end
        for (int j = 0; j < 10; j++) chk($sformatf("v%0d_cell%0d_bad_cycles", tag, j), err[j], 0);
        chk($sformatf("v%0d_busy_cycles", tag), nb, F1);
    endtask

    // Independent receiver: find the start level, sample every bit at its middle.
    function automatic logic line_of(input int w);
        return (w == 2) ? line2 : line;
    endfunction

    task automatic wait_n(input int n, output bit ab);
        ab = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (reset !== 1'b1) ab = 1'b1;
        end
    endtask

    task automatic rx(input int w, input int cpb);
        logic [7:0] word;
        logic [7:0] exp;
        bit         ab;
        forever begin
            do @(negedge clk); while (!(reset === 1'b1 && line_of(w) === 1'b0));
            wait_n(cpb / 2, ab);
            if (ab) continue;
            chk($sformatf("rx%0d_start_mid", w), longint'(line_of(w) === 1'b0), 1);
            for (int i = 0; i < 8; i++) begin
                wait_n(cpb, ab);
                if (ab) break;
                word[i] = line_of(w);
            end
            if (ab) continue;
            wait_n(cpb, ab);
            if (ab) continue;
            chk($sformatf("rx%0d_stop_mid", w), longint'(line_of(w) === 1'b1), 1);
            if ((w == 1 && q1.size() == 0) || (w == 2 && q2.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL rx%0d_unexpected_frame: got %0h expected none", w, word);
            end else begin
                exp = (w == 1) ? q1.pop_front() : q2.pop_front();
                chk($sformatf("rx%0d_word", w), longint'(word), longint'(exp));
            end
        end
    endtask

    initial begin
        fork
            rx(1, CPB);
            rx(2, CPB2);
        join_none
    end

    initial begin
        vec_t vecs[5];
        bit   acc;
        int   nb, nhi, nlo;

        vecs[0] = '{8'hA5, 8'b10100101};
        vecs[1] = '{8'h01, 8'b10000000};
        vecs[2] = '{8'h80, 8'b00000001};
        vecs[3] = '{8'h0F, 8'b11110000};
        vecs[4] = '{8'h6B, 8'b11010110};

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_line",   longint'(line),   1);
        chk("rst_busy",   longint'(busy),   0);
        chk("rst_ready",  longint'(ready),  1);
        chk("rst_line2",  longint'(line2),  1);
        chk("rst_ready2", longint'(ready2), 1);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Isolated frames
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i].data, vecs[i].seq);
        wait_idle();

        // Back-to-back: second word held, no gap between frames
        attempt(8'h55, acc);
        attempt(8'h0F, acc);
        chk("b2b_ready_after_second", longint'(ready), 0);
        repeat (F1 - 2) @(negedge clk);
        chk("b2b_last_stop_line",  longint'(line),  1);
        chk("b2b_last_stop_ready", longint'(ready), 0);
        @(negedge clk);
        chk("b2b_second_start_line", longint'(line),  0);
        chk("b2b_second_ready",      longint'(ready), 1);
        chk("b2b_second_busy",       longint'(busy),  1);
        wait_idle();

        // Overflow: third word while slot is full is dropped
        attempt(8'h12, acc);
        attempt(8'h34, acc);
        repeat (200) @(negedge clk);
        attempt(8'hFF, acc);
        wait_idle();
        chk("ovf_queue_drained", q1.size(), 0);

        // Random traffic
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 1400)) @(negedge clk);
            attempt(8'($urandom), acc);
        end
        wait_idle();

        // Mid-frame reset during bit 3
        attempt(8'h3C, acc);
        repeat (560) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_line",  longint'(line),  1);
        chk("midrst_busy",  longint'(busy),  0);
        chk("midrst_ready", longint'(ready), 1);
        model_reset();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        run_vec(9, 8'hC3, 8'b11000011);
        wait_idle();

        // Two stop bits, 16 cycles per bit
        chk("s2_ready", longint'(ready2), 1);
        start2     = 1'b1;
        send_data2 = 8'h81;
        q2.push_back(8'h81);
        @(posedge clk);
        @(negedge clk);
        start2     = 1'b0;
        send_data2 = 8'h7E;
        nb = 0; nhi = 0; nlo = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy2 === 1'b1) nb++;
            if (k >= 144 && k < 176 && line2 === 1'b1) nhi++;
            if (k < 16 && line2 === 1'b0) nlo++;
            @(negedge clk);
        end
        chk("s2_busy_cycles", nb,  176);
        chk("s2_stop_high",   nhi, 32);
        chk("s2_start_low",   nlo, 16);
        wait_idle();

        repeat (20) @(negedge clk);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 14745600, clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port send_data  input  DATA_WIDTH  word to transmit; sampled only on an accepting edge.
REQ-008 SHALL have port start  input  1  request valid; a word is accepted on a rising edge where start=1 and ready=1.
REQ-009 SHALL have port ready  output  1  holding slot empty; a word can be accepted.
REQ-010 SHALL have port busy  output  1  a frame is on the line (state not IDLE).
REQ-011 SHALL have port line  output  1  serial TX line; registered; idle high.

Function
REQ-012 SHALL derive CLKS_PER_BIT = CLK_FREQ / BAUDRATE (integer division; 128 at defaults) and SHALL hold every bit on line for exactly CLKS_PER_BIT cycles.
REQ-013 SHALL size the bit-timing counter to hold CLKS_PER_BIT-1 and the bit index to hold DATA_WIDTH-1.
REQ-014 SHALL implement the state machine IDLE -> START -> DATA -> STOP -> (START or IDLE).
REQ-015 SHALL drive line = 1 in IDLE and STOP, 0 in START, and shift-register bit 0 in DATA.
REQ-016 SHALL send data bits LSB first, DATA_WIDTH bits per frame.
REQ-017 SHALL hold STOP for STOP_BITS*CLKS_PER_BIT cycles.
REQ-018 SHALL contain a one-word holding register (pending flag plus data), with ready = !pending combinationally.
REQ-019 On an accepting edge in IDLE with pending=0, SHALL load send_data directly into the shift register and enter START, so line is low from that edge.
REQ-020 On an accepting edge in START, DATA or STOP, SHALL store send_data into the holding register and set pending.
REQ-021 At the final cycle of STOP: if pending=1, SHALL enter START on the next edge, load the shift register from the holding register and clear pending, with no idle cycle between frames; if pending=0, SHALL enter IDLE.
REQ-022 SHALL ignore start while ready=0; send_data and the holding register SHALL be unaffected.
REQ-023 SHALL not allow changes on send_data or start during a frame to alter the frame in progress.
REQ-024 At defaults, SHALL produce a single isolated frame lasting (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT = 1280 cycles from the first low cycle to the return to IDLE.
REQ-025 SHALL assert busy from the edge that enters START until the edge that enters IDLE.

Reset
REQ-026 When reset=0, SHALL immediately set state=IDLE, line=1, busy=0, pending=0 (so ready=1), and clear all counters and the shift register.
REQ-027 Reset asserted mid-frame SHALL abort the frame with line high at once; the first accepted word after release SHALL start a complete new frame.
REQ-028 Reset release SHALL be synchronised internally so the first active edge after deassertion sees a stable IDLE state.

Verification
REQ-029 Single frame: defaults, send_data=8'hA5 with start for 1 cycle -> line reads 0 for 128 cycles, then 1,0,1,0,0,1,0,1 at 128 cycles each, then 1; busy=1 for exactly 1280 cycles.
REQ-030 Back-to-back: accept 8'h55, then accept 8'h0F while busy -> ready=0 after the second accept; the second start bit follows the first stop bit with zero gap; ready=1 again when the second frame starts.
REQ-031 Overflow: with pending=1, pulse start with 8'hFF -> the word is ignored; the frames on the line are only the first and pending words.
REQ-032 Mid-frame reset: assert reset=0 during bit 3 of 8'h3C -> line=1, busy=0, ready=1 immediately; after release, 8'hC3 transmits correctly.
REQ-033 STOP_BITS=2, CLK_FREQ=1600, BAUDRATE=100 (16 cycles/bit): send 8'h81 -> frame lasts 11*16=176 cycles, with 32 high stop cycles.
REQ-034 Bench SHALL decode line with an independent reference receiver sampling mid-bit, and compare against every accepted word in order.
